// File: rtl/edge_detect_pkg.sv
// Shared definitions for the multi-channel edge detector: the per-channel
// edge-select encoding and the width of the pulse-stretch down-counter.
package edge_detect_pkg;

  // Per-channel edge select, two bits per channel on the mode bus.
  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } mode_t;

  // STRETCH is limited to 1..255, so an 8-bit down-counter always holds it.
  localparam int STRETCH_W = 8;

endpackage

// File: rtl/edge_chan.sv
// One channel of the edge detector: synchroniser chain, history flop,
// raw edge strobes, mode qualification, pulse stretcher, sticky flag and
// saturating event counter.
module edge_chan
  import edge_detect_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int STRETCH     = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             sig_in,
  input  mode_t            mode,
  input  logic             clr,
  output logic             sync_out,
  output logic             p_pulse,
  output logic             n_pulse,
  output logic             evt_pulse,
  output logic             evt_flag,
  output logic [CNT_W-1:0] evt_cnt
);

  localparam logic [STRETCH_W-1:0] STRETCH_LOAD = STRETCH_W'(STRETCH);
  localparam logic [CNT_W-1:0]     CNT_MAX      = {CNT_W{1'b1}};

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   hist_reg;
  logic [STRETCH_W-1:0]   stretch_reg;
  logic [STRETCH_W-1:0]   stretch_next;
  logic                   flag_reg;
  logic                   flag_next;
  logic [CNT_W-1:0]       cnt_reg;
  logic [CNT_W-1:0]       cnt_next;
  logic                   qual_evt;

  // Shift the asynchronous input through the synchroniser chain.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], sig_in};
    end
  end

  assign sync_out = sync_reg[SYNC_STAGES-1];

  // History flop: previous synchronised level; starts at 0 so a level held
  // high through reset release still yields one rising strobe.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hist_reg <= 1'b0;
    end else begin
      hist_reg <= sync_out;
    end
  end

  assign p_pulse = sync_out & ~hist_reg;
  assign n_pulse = ~sync_out & hist_reg;

  // Qualify the raw strobes with the edge select of this channel.
  always_comb begin
    qual_evt = 1'b0;
    case (mode)
      MODE_RISE: qual_evt = p_pulse;
      MODE_FALL: qual_evt = n_pulse;
      MODE_BOTH: qual_evt = p_pulse | n_pulse;
      default:   qual_evt = 1'b0;
    endcase
  end

  // Next state for the stretcher, flag and counter; an event always wins
  // over clear so a coincident event is recorded as the first after clear.
  always_comb begin
    stretch_next = stretch_reg;
    flag_next    = flag_reg;
    cnt_next     = cnt_reg;
    if (qual_evt) begin
      stretch_next = STRETCH_LOAD;
    end else if (stretch_reg != '0) begin
      stretch_next = stretch_reg - 1'b1;
    end
    if (clr) begin
      flag_next = qual_evt;
      cnt_next  = qual_evt ? CNT_W'(1) : '0;
    end else if (qual_evt) begin
      flag_next = 1'b1;
      if (cnt_reg != CNT_MAX) begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  // Register stretcher, flag and counter state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stretch_reg <= '0;
      flag_reg    <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      stretch_reg <= stretch_next;
      flag_reg    <= flag_next;
      cnt_reg     <= cnt_next;
    end
  end

  assign evt_pulse = (stretch_reg != '0);
  assign evt_flag  = flag_reg;
  assign evt_cnt   = cnt_reg;

endmodule

// File: rtl/edge_detect_mc.sv
// Multi-channel edge detector top: one edge_chan per input channel and the
// OR of all sticky flags as the interrupt.
module edge_detect_mc
  import edge_detect_pkg::*;
#(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int STRETCH     = 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [CH-1:0]       sig_in,
  input  logic [2*CH-1:0]     mode,
  input  logic [CH-1:0]       clr,
  output logic [CH-1:0]       sync_out,
  output logic [CH-1:0]       p_pulse,
  output logic [CH-1:0]       n_pulse,
  output logic [CH-1:0]       evt_pulse,
  output logic [CH-1:0]       evt_flag,
  output logic [CH*CNT_W-1:0] evt_cnt,
  output logic                irq
);

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_chan
      edge_chan #(
        .SYNC_STAGES (SYNC_STAGES),
        .CNT_W       (CNT_W),
        .STRETCH     (STRETCH)
      ) u_chan (
        .clk       (clk),
        .rstn      (rstn),
        .sig_in    (sig_in[gi]),
        .mode      (mode_t'(mode[2*gi +: 2])),
        .clr       (clr[gi]),
        .sync_out  (sync_out[gi]),
        .p_pulse   (p_pulse[gi]),
        .n_pulse   (n_pulse[gi]),
        .evt_pulse (evt_pulse[gi]),
        .evt_flag  (evt_flag[gi]),
        .evt_cnt   (evt_cnt[gi*CNT_W +: CNT_W])
      );
    end
  endgenerate

  assign irq = |evt_flag;

endmodule
